regfile_sb: RTL and testbench

- Parametrised integer register file with N read ports, M write ports, same-cycle write-to-read bypass and a tagged busy scoreboard.
- Sits between decode/issue and the writeback stage of the core.
- Issue marks a destination register pending under a tag. Writeback with a matching tag commits the data and clears pending.
- Read ports report data and a ready flag, so issue stalls on RAW hazards without a separate scoreboard.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/rf_scoreboard.sv | 71 +++++++
 rtl/regfile_sb.sv | 95 +++++++++
 tb/tb_regfile_sb.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file with busy scoreboard.
package regfile_pkg;

    localparam int unsigned XLEN_D  = 64;
    localparam int unsigned NREG_D  = 32;
    localparam int unsigned TAG_W_D = 4;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy/tag scoreboard: decides which writebacks are current and tracks pending registers.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREG     = NREG_D,
    parameter int unsigned NWR      = 2,
    parameter int unsigned TAG_W    = TAG_W_D,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    input  logic [TAG_W-1:0]     iss_tag,
    input  logic [NWR-1:0]       wen,
    input  logic [NWR*AW-1:0]    waddr,
    input  logic [NWR*TAG_W-1:0] wtag,
    input  logic                 flush,
    output logic [NREG-1:0]      busy,
    output logic [NWR-1:0]       accept
);

    logic [NREG-1:0]  busy_q, busy_d;
    logic [TAG_W-1:0] tag_q [NREG];
    logic [TAG_W-1:0] tag_d [NREG];

    assign busy = busy_q;

    // A write to a pending register is current only if it carries the latest tag.
    always_comb begin
        accept = '0;
        for (int i = 0; i < NWR; i++) begin
            accept[i] = wen[i]
                && !(ZERO_REG && (waddr[i*AW +: AW] == '0))
                && (!busy_q[waddr[i*AW +: AW]]
                    || (tag_q[waddr[i*AW +: AW]] == wtag[i*TAG_W +: TAG_W]));
        end
    end

    // Clears (flush, writeback) first, then issue so it overrides both.
    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        if (flush) begin
            busy_d = '0;
        end
        for (int i = 0; i < NWR; i++) begin
            if (accept[i]) begin
                busy_d[waddr[i*AW +: AW]] = 1'b0;
            end
        end
        if (iss_valid && !(ZERO_REG && (iss_rd == '0))) begin
            busy_d[iss_rd] = 1'b1;
            tag_d[iss_rd]  = iss_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
            for (int r = 0; r < NREG; r++) begin
                tag_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-ported integer register file with write-to-read bypass and tagged busy scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_D,
    parameter int unsigned NREG     = NREG_D,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 2,
    parameter int unsigned TAG_W    = TAG_W_D,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*XLEN-1:0]  rdata,
    output logic [NRD-1:0]       rready,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    input  logic [TAG_W-1:0]     iss_tag,
    input  logic [NWR-1:0]       wen,
    input  logic [NWR*AW-1:0]    waddr,
    input  logic [NWR*XLEN-1:0]  wdata,
    input  logic [NWR*TAG_W-1:0] wtag,
    input  logic                 flush,
    output logic [NREG-1:0]      busy
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NWR-1:0]  accept;

    rf_scoreboard #(
        .NREG     (NREG),
        .NWR      (NWR),
        .TAG_W    (TAG_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_tag   (iss_tag),
        .wen       (wen),
        .waddr     (waddr),
        .wtag      (wtag),
        .flush     (flush),
        .busy      (busy),
        .accept    (accept)
    );

    // Ascending loop: the highest-index accepted port wins an address collision.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NWR; i++) begin
            if (accept[i]) begin
                regs_d[waddr[i*AW +: AW]] = wdata[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdata  = '0;
        rready = '0;
        for (int k = 0; k < NRD; k++) begin
            if (!rst) begin
                rdata[k*XLEN +: XLEN] = '0;
                rready[k]             = 1'b0;
            end else if (ZERO_REG && (raddr[k*AW +: AW] == '0)) begin
                rdata[k*XLEN +: XLEN] = '0;
                rready[k]             = 1'b1;
            end else begin
                rdata[k*XLEN +: XLEN] = regs_q[raddr[k*AW +: AW]];
                rready[k]             = !busy[raddr[k*AW +: AW]];
                for (int i = 0; i < NWR; i++) begin
                    if (accept[i] && (waddr[i*AW +: AW] == raddr[k*AW +: AW])) begin
                        rdata[k*XLEN +: XLEN] = wdata[i*XLEN +: XLEN];
                        rready[k]             = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb.
module tb_regfile_sb;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned NREG  = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned NWR   = 2;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned AW    = 5;

    logic                 clk;
    logic                 rst;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*XLEN-1:0]  rdata;
    logic [NRD-1:0]       rready;
    logic                 iss_valid;
    logic [AW-1:0]        iss_rd;
    logic [TAG_W-1:0]     iss_tag;
    logic [NWR-1:0]       wen;
    logic [NWR*AW-1:0]    waddr;
    logic [NWR*XLEN-1:0]  wdata;
    logic [NWR*TAG_W-1:0] wtag;
    logic                 flush;
    logic [NREG-1:0]      busy;

    int tests;
    int fails;

    regfile_sb #(
        .XLEN     (XLEN),
        .NREG     (NREG),
        .NRD      (NRD),
        .NWR      (NWR),
        .TAG_W    (TAG_W),
        .ZERO_REG (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .raddr     (raddr),
        .rdata     (rdata),
        .rready    (rready),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_tag   (iss_tag),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .wtag      (wtag),
        .flush     (flush),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_in();
        iss_valid = 1'b0;
        iss_rd    = '0;
        iss_tag   = '0;
        wen       = '0;
        waddr     = '0;
        wdata     = '0;
        wtag      = '0;
        flush     = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                          input logic [TAG_W-1:0] t);
        wen[p]                  = 1'b1;
        waddr[p*AW +: AW]       = a;
        wdata[p*XLEN +: XLEN]   = d;
        wtag[p*TAG_W +: TAG_W]  = t;
    endtask

    task automatic set_iss(input logic [AW-1:0] a, input logic [TAG_W-1:0] t);
        iss_valid = 1'b1;
        iss_rd    = a;
        iss_tag   = t;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        raddr[k*AW +: AW] = a;
    endtask

    // Commit current inputs at the next edge, then drop them; leaves time at edge+1.
    task automatic step();
        @(posedge clk);
        #1;
        clear_in();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_in();
        raddr = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        tests++;
        if (busy !== 32'h0) begin
            fails++;
            $display("FAIL reset_busy: got %h want %h", busy, 32'h0);
        end
        rst = 1'b1;
        set_wr(0, 5'd5, 64'hAA, 4'd0);
        set_rd(0, 5'd5);
        step();
        tests++;
        if (rdata[63:0] !== 64'hAA || rready[0] !== 1'b1) begin
            fails++;
            $display("FAIL reset_prewrite: got %h/%b want %h/1", rdata[63:0], rready[0], 64'hAA);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (rdata !== '0 || rready !== 2'b00) begin
            fails++;
            $display("FAIL reset_comb_zero: got %h/%b want 0/00", rdata, rready);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if (rdata[63:0] !== 64'h0 || busy !== 32'h0 || rready[0] !== 1'b1) begin
            fails++;
            $display("FAIL reset_x5_cleared: got %h busy %h rdy %b want 0 busy 0 rdy 1",
                     rdata[63:0], busy, rready[0]);
        end
    endtask

    task automatic test_basic();
        set_wr(0, 5'd3, 64'h1234_5678_9ABC_DEF0, 4'd0);
        set_rd(0, 5'd3);
        #1;
        tests++;
        if (rdata[63:0] !== 64'h1234_5678_9ABC_DEF0 || rready[0] !== 1'b1) begin
            fails++;
            $display("FAIL basic_bypass: got %h/%b want 123456789abcdef0/1",
                     rdata[63:0], rready[0]);
        end
        step();
        tests++;
        if (rdata[63:0] !== 64'h1234_5678_9ABC_DEF0 || rready[0] !== 1'b1) begin
            fails++;
            $display("FAIL basic_array: got %h/%b want 123456789abcdef0/1",
                     rdata[63:0], rready[0]);
        end
    endtask

    task automatic test_scoreboard();
        set_iss(5'd7, 4'd2);
        set_rd(0, 5'd7);
        step();
        tests++;
        if (busy[7] !== 1'b1 || rready[0] !== 1'b0) begin
            fails++;
            $display("FAIL sb_issue: got busy %b rdy %b want 1/0", busy[7], rready[0]);
        end
        set_wr(0, 5'd7, 64'h99, 4'd1);
        #1;
        tests++;
        if (rready[0] !== 1'b0 || rdata[63:0] !== 64'h0) begin
            fails++;
            $display("FAIL sb_stale_comb: got %h/%b want 0/0", rdata[63:0], rready[0]);
        end
        step();
        tests++;
        if (busy[7] !== 1'b1 || rdata[63:0] !== 64'h0) begin
            fails++;
            $display("FAIL sb_stale_kept: got busy %b data %h want 1/0", busy[7], rdata[63:0]);
        end
        set_wr(1, 5'd7, 64'h55, 4'd2);
        #1;
        tests++;
        if (rready[0] !== 1'b1 || rdata[63:0] !== 64'h55) begin
            fails++;
            $display("FAIL sb_match_bypass: got %h/%b want 55/1", rdata[63:0], rready[0]);
        end
        step();
        tests++;
        if (busy[7] !== 1'b0 || rdata[63:0] !== 64'h55 || rready[0] !== 1'b1) begin
            fails++;
            $display("FAIL sb_cleared: got busy %b data %h rdy %b want 0/55/1",
                     busy[7], rdata[63:0], rready[0]);
        end
    endtask

    task automatic test_collision();
        set_wr(0, 5'd4, 64'h11, 4'd0);
        set_wr(1, 5'd4, 64'h22, 4'd0);
        set_rd(0, 5'd4);
        #1;
        tests++;
        if (rdata[63:0] !== 64'h22) begin
            fails++;
            $display("FAIL coll_bypass: got %h want 22", rdata[63:0]);
        end
        step();
        tests++;
        if (rdata[63:0] !== 64'h22) begin
            fails++;
            $display("FAIL coll_array: got %h want 22", rdata[63:0]);
        end
        set_wr(0, 5'd0, 64'hFF, 4'd0);
        set_iss(5'd0, 4'd1);
        set_rd(1, 5'd0);
        #1;
        tests++;
        if (rdata[127:64] !== 64'h0 || rready[1] !== 1'b1) begin
            fails++;
            $display("FAIL x0_bypass: got %h/%b want 0/1", rdata[127:64], rready[1]);
        end
        step();
        tests++;
        if (busy[0] !== 1'b0 || rdata[127:64] !== 64'h0 || rready[1] !== 1'b1) begin
            fails++;
            $display("FAIL x0_after: got busy %b data %h rdy %b want 0/0/1",
                     busy[0], rdata[127:64], rready[1]);
        end
    endtask

    task automatic test_issue_wb();
        set_iss(5'd9, 4'd3);
        step();
        set_wr(0, 5'd9, 64'h77, 4'd3);
        set_iss(5'd9, 4'd5);
        set_rd(0, 5'd9);
        #1;
        tests++;
        if (rdata[63:0] !== 64'h77 || rready[0] !== 1'b1) begin
            fails++;
            $display("FAIL iwb_bypass: got %h/%b want 77/1", rdata[63:0], rready[0]);
        end
        step();
        tests++;
        if (busy[9] !== 1'b1 || rready[0] !== 1'b0 || rdata[63:0] !== 64'h77) begin
            fails++;
            $display("FAIL iwb_retag: got busy %b rdy %b data %h want 1/0/77",
                     busy[9], rready[0], rdata[63:0]);
        end
        set_wr(1, 5'd9, 64'h88, 4'd3);
        #1;
        tests++;
        if (rready[0] !== 1'b0 || rdata[63:0] !== 64'h77) begin
            fails++;
            $display("FAIL iwb_old_tag: got %h/%b want 77/0", rdata[63:0], rready[0]);
        end
        step();
        set_wr(0, 5'd9, 64'hAB, 4'd5);
        step();
        tests++;
        if (busy[9] !== 1'b0 || rdata[63:0] !== 64'hAB || rready[0] !== 1'b1) begin
            fails++;
            $display("FAIL iwb_new_tag: got busy %b data %h rdy %b want 0/ab/1",
                     busy[9], rdata[63:0], rready[0]);
        end
    endtask

    task automatic test_flush();
        set_wr(0, 5'd1, 64'h101, 4'd0);
        set_wr(1, 5'd2, 64'h202, 4'd0);
        step();
        set_wr(0, 5'd6, 64'h606, 4'd0);
        step();
        set_iss(5'd1, 4'd1);
        step();
        set_iss(5'd2, 4'd2);
        step();
        set_iss(5'd6, 4'd6);
        step();
        tests++;
        if (busy !== 32'h0000_0046) begin
            fails++;
            $display("FAIL flush_pre_busy: got %h want 00000046", busy);
        end
        flush = 1'b1;
        set_iss(5'd8, 4'd7);
        step();
        tests++;
        if (busy !== 32'h0000_0100) begin
            fails++;
            $display("FAIL flush_busy: got %h want 00000100", busy);
        end
        set_rd(0, 5'd1);
        set_rd(1, 5'd2);
        #1;
        tests++;
        if (rdata[63:0] !== 64'h101 || rdata[127:64] !== 64'h202 || rready !== 2'b11) begin
            fails++;
            $display("FAIL flush_data12: got %h %h/%b want 101 202/11",
                     rdata[63:0], rdata[127:64], rready);
        end
        set_rd(0, 5'd6);
        set_rd(1, 5'd8);
        #1;
        tests++;
        if (rdata[63:0] !== 64'h606 || rready !== 2'b01) begin
            fails++;
            $display("FAIL flush_data6: got %h/%b want 606/01", rdata[63:0], rready);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_scoreboard();
        test_collision();
        test_issue_wb();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
